// File: rtl/ultrasonic_sensor_trigger.sv
`timescale 1ns/1ps
// HC-SR04 initiator: drives the trigger pulse, times the echo window against rise and
// length limits, and enforces a quiet hold-off before the next measurement may start.
module ultrasonic_sensor_trigger #(
    parameter int TRIG_CYCLES_P       = 500,
    parameter int ECHO_RISE_TIMEOUT_P = 50_000,
    parameter int ECHO_MAX_CYCLES_P   = 1_900_000,
    parameter int HOLDOFF_CYCLES_P    = 3_000_000,
    parameter int COUNTER_WIDTH_P     = 22
) (
    input  logic       Clk_i,
    input  logic       Reset_i,
    input  logic       Start_i,
    input  logic       Continuous_i,
    input  logic       Echo_i,
    output logic       Trigger_o,
    output logic       Busy_o,
    output logic       Done_o,
    output logic       Timeout_o,
    output logic [1:0] Error_code_o
);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, ECHO_HIGH, HOLDOFF} state_t;

    localparam logic [COUNTER_WIDTH_P-1:0] TRIG_LAST = COUNTER_WIDTH_P'(TRIG_CYCLES_P - 1);
    localparam logic [COUNTER_WIDTH_P-1:0] RISE_LAST = COUNTER_WIDTH_P'(ECHO_RISE_TIMEOUT_P - 1);
    localparam logic [COUNTER_WIDTH_P-1:0] ECHO_LAST = COUNTER_WIDTH_P'(ECHO_MAX_CYCLES_P - 1);
    localparam logic [COUNTER_WIDTH_P-1:0] HOLD_LAST = COUNTER_WIDTH_P'(HOLDOFF_CYCLES_P - 1);

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_NO_RISE  = 2'b01;
    localparam logic [1:0] ERR_TOO_LONG = 2'b10;

    state_t                     state_q, state_d;
    logic [COUNTER_WIDTH_P-1:0] cnt_q, cnt_d;
    logic                       echo_meta_q, echo_s_q;
    logic                       trigger_q, trigger_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       timeout_q, timeout_d;
    logic [1:0]                 err_q, err_d;

    // Echo checks come before their timeouts, so a tie resolves in favour of the sensor.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + COUNTER_WIDTH_P'(1);
        done_d    = 1'b0;
        timeout_d = 1'b0;
        err_d     = err_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (Start_i || Continuous_i) state_d = TRIG;
            end
            TRIG: begin
                if (cnt_q == TRIG_LAST) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (echo_s_q) begin
                    state_d = ECHO_HIGH;
                end else if (cnt_q == RISE_LAST) begin
                    state_d   = HOLDOFF;
                    timeout_d = 1'b1;
                    err_d     = ERR_NO_RISE;
                end
            end
            ECHO_HIGH: begin
                if (!echo_s_q) begin
                    state_d = HOLDOFF;
                    done_d  = 1'b1;
                    err_d   = ERR_OK;
                end else if (cnt_q == ECHO_LAST) begin
                    state_d   = HOLDOFF;
                    timeout_d = 1'b1;
                    err_d     = ERR_TOO_LONG;
                end
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    cnt_d = cnt_q;
                    if (!echo_s_q) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
        trigger_d = (state_d == TRIG);
        busy_d    = (state_d != IDLE);
    end

    always_ff @(posedge Clk_i or negedge Reset_i) begin
        if (!Reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            echo_meta_q <= 1'b0;
            echo_s_q    <= 1'b0;
            trigger_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
            err_q       <= ERR_OK;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            echo_meta_q <= Echo_i;
            echo_s_q    <= echo_meta_q;
            trigger_q   <= trigger_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
            err_q       <= err_d;
        end
    end

    assign Trigger_o    = trigger_q;
    assign Busy_o       = busy_q;
    assign Done_o       = done_q;
    assign Timeout_o    = timeout_q;
    assign Error_code_o = err_q;
endmodule

// File: tb/tb_ultrasonic_sensor_trigger.sv
`timescale 1ns/1ps
// Bench for ultrasonic_sensor_trigger: hand-derived vector table, corner-case sequences and
// randomized measurements checked cycle by cycle against an event-level protocol model.
module tb_ultrasonic_sensor_trigger;
    localparam int TRIG    = 5;
    localparam int RISE_TO = 20;
    localparam int MAXLEN  = 50;
    localparam int HOLDOFF = 30;
    localparam int DEPTH   = 12000;
    localparam int NVEC    = 8;

    // Offsets are in clock edges relative to the trigger fall; r_off of -1 means no echo.
    typedef struct {
        int r_off;
        int len;
        int busy_off;
        int exp_ev_off;
        int exp_code;
        int exp_exit_off;
    } vec_t;

    logic       Clk_i        = 1'b0;
    logic       Reset_i      = 1'b0;
    logic       Start_i      = 1'b0;
    logic       Continuous_i = 1'b0;
    logic       Echo_i       = 1'b0;
    logic       Trigger_o;
    logic       Busy_o;
    logic       Done_o;
    logic       Timeout_o;
    logic [1:0] Error_code_o;

    always #5 Clk_i = ~Clk_i;

    ultrasonic_sensor_trigger #(
        .TRIG_CYCLES_P      (TRIG),
        .ECHO_RISE_TIMEOUT_P(RISE_TO),
        .ECHO_MAX_CYCLES_P  (MAXLEN),
        .HOLDOFF_CYCLES_P   (HOLDOFF),
        .COUNTER_WIDTH_P    (8)
    ) dut (
        .Clk_i       (Clk_i),
        .Reset_i     (Reset_i),
        .Start_i     (Start_i),
        .Continuous_i(Continuous_i),
        .Echo_i      (Echo_i),
        .Trigger_o   (Trigger_o),
        .Busy_o      (Busy_o),
        .Done_o      (Done_o),
        .Timeout_o   (Timeout_o),
        .Error_code_o(Error_code_o)
    );

    int compared   = 0;
    int mismatched = 0;

    // Planned pin activity and expected outputs, indexed by the clock edge they belong to.
    bit         pin_start [DEPTH];
    bit         pin_cont  [DEPTH];
    bit         pin_echo  [DEPTH];
    bit         exp_trig  [DEPTH];
    bit         exp_busy  [DEPTH];
    bit         exp_done  [DEPTH];
    bit         exp_to    [DEPTH];
    logic [1:0] exp_err   [DEPTH];

    int         edge_idx = 0;
    int         plan_end = 0;
    int         last_s   = 0;
    int         last_e   = 0;
    logic [1:0] cur_err  = 2'b00;

    bit prev_trig = 1'b0;
    bit prev_busy = 1'b0;
    int meas_trig_count;
    int meas_done_count;
    int meas_to_count;
    int meas_event_kind;
    int meas_rise_q[$];
    int meas_event_q[$];
    int meas_exit_q[$];

    vec_t vecs [NVEC];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int nth(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -100000;
    endfunction

    task automatic clear_meas();
        meas_trig_count = 0;
        meas_done_count = 0;
        meas_to_count   = 0;
        meas_event_kind = 0;
        meas_rise_q.delete();
        meas_event_q.delete();
        meas_exit_q.delete();
    endtask

    task automatic clear_plan_from(input int k0);
        for (int k = k0; k < DEPTH; k++) begin
            pin_start[k] = 1'b0;
            pin_cont[k]  = 1'b0;
            pin_echo[k]  = 1'b0;
            exp_trig[k]  = 1'b0;
            exp_busy[k]  = 1'b0;
            exp_done[k]  = 1'b0;
            exp_to[k]    = 1'b0;
            exp_err[k]   = 2'b00;
        end
    endtask

    task automatic plan_idle(input int n);
        for (int k = plan_end; k < plan_end + n; k++) begin
            exp_trig[k] = 1'b0;
            exp_busy[k] = 1'b0;
            exp_done[k] = 1'b0;
            exp_to[k]   = 1'b0;
            exp_err[k]  = cur_err;
        end
        plan_end += n;
    endtask

    // Event-level model of one measurement. mode: 0 start pulse, 1 continuous held for the
    // whole cycle, 2 continuous dropped right after the cycle begins.
    task automatic plan_shot(input int mode, input int r_off, input int len, input int busy_off);
        int s, f, r, p, e, x, boff;
        bit ok;
        logic [1:0] code;
        if (plan_end + 400 >= DEPTH) begin
            $display("[TB] FAIL plan_depth: got %0d, expected below %0d", plan_end, DEPTH - 400);
            $fatal(1, "[TB] plan table exhausted");
        end
        s = plan_end;
        f = s + TRIG;
        r = f + r_off;
        p = r + len;
        if (mode == 0) pin_start[s] = 1'b1;
        else           pin_cont[s]  = 1'b1;
        if (r_off >= 0)
            for (int k = r; k < p; k++) pin_echo[k] = 1'b1;
        // The controller sees a pin change two edges late and decides on the edge after that.
        if (r_off < 0 || r + 2 > f + RISE_TO) begin
            e = f + RISE_TO;  ok = 1'b0;  code = 2'b01;
        end else if (len <= MAXLEN) begin
            e = p + 2;        ok = 1'b1;  code = 2'b00;
        end else begin
            e = r + 2 + MAXLEN; ok = 1'b0; code = 2'b10;
        end
        x = e + HOLDOFF;
        while (pin_echo[x-2]) x++;
        if (mode == 1) for (int k = s; k <= x; k++) pin_cont[k] = 1'b1;
        if (mode == 2) begin
            pin_cont[s+1] = 1'b1;
            pin_cont[s+2] = 1'b1;
        end
        if (busy_off > 0) begin
            boff = (busy_off > x - s) ? x - s : busy_off;
            pin_start[s+boff] = 1'b1;
        end
        for (int k = s; k <= x; k++) begin
            exp_trig[k] = (k < f);
            exp_busy[k] = (k < x);
            exp_done[k] = (k == e) && ok;
            exp_to[k]   = (k == e) && !ok;
            exp_err[k]  = (k >= e) ? code : cur_err;
        end
        cur_err  = code;
        last_s   = s;
        last_e   = e;
        plan_end = x + 1;
    endtask

    task automatic applyStimulus();
        Start_i      = pin_start[edge_idx];
        Continuous_i = pin_cont[edge_idx];
        Echo_i       = pin_echo[edge_idx];
        @(posedge Clk_i);
        #1;
        checkOutput($sformatf("cycle%0d", edge_idx),
                    {Trigger_o, Busy_o, Done_o, Timeout_o, Error_code_o},
                    {exp_trig[edge_idx], exp_busy[edge_idx], exp_done[edge_idx],
                     exp_to[edge_idx], exp_err[edge_idx]});
        if (Trigger_o && !prev_trig) meas_rise_q.push_back(edge_idx);
        if (Trigger_o) meas_trig_count++;
        if (Done_o) begin
            meas_done_count++;
            meas_event_kind = 1;
            meas_event_q.push_back(edge_idx);
        end
        if (Timeout_o) begin
            meas_to_count++;
            meas_event_kind = 2;
            meas_event_q.push_back(edge_idx);
        end
        if (!Busy_o && prev_busy) meas_exit_q.push_back(edge_idx);
        prev_trig = Trigger_o;
        prev_busy = Busy_o;
        edge_idx++;
    endtask

    task automatic run_until(input int k);
        while (edge_idx < k && edge_idx < DEPTH) applyStimulus();
    endtask

    // Asynchronous reset a few ns after an edge, held for three clocks, then re-based plan.
    task automatic reset_check(input string tag);
        #2;
        Reset_i      = 1'b0;
        Echo_i       = 1'b0;
        Start_i      = 1'b0;
        Continuous_i = 1'b0;
        #1;
        checkOutput({tag, "_rst_trigger"}, Trigger_o, 0);
        checkOutput({tag, "_rst_busy"}, Busy_o, 0);
        checkOutput({tag, "_rst_done"}, Done_o, 0);
        checkOutput({tag, "_rst_timeout"}, Timeout_o, 0);
        checkOutput({tag, "_rst_code"}, Error_code_o, 0);
        repeat (3) begin
            @(posedge Clk_i);
            #1;
            checkOutput({tag, "_rst_hold"}, {Trigger_o, Busy_o, Done_o, Timeout_o, Error_code_o}, 0);
        end
        Reset_i = 1'b1;
        clear_plan_from(edge_idx);
        plan_end  = edge_idx;
        cur_err   = 2'b00;
        prev_trig = 1'b0;
        prev_busy = 1'b0;
    endtask

    initial begin
        int cont_s [3];
        int cont_e [3];
        int r_off, len, busy, gap, mode;

        vecs[0] = '{8, 12, 3, 22, 0, 30};
        vecs[1] = '{-1, 0, 4, 20, 1, 30};
        vecs[2] = '{2, 80, 10, 54, 2, 30};
        vecs[3] = '{2, 95, 0, 54, 2, 45};
        vecs[4] = '{18, 50, 6, 70, 0, 30};
        vecs[5] = '{19, 10, 0, 20, 1, 30};
        vecs[6] = '{3, 51, 0, 55, 2, 30};
        vecs[7] = '{0, 1, 2, 3, 0, 30};

        clear_plan_from(0);
        clear_meas();

        #1;
        checkOutput("reset_trigger", Trigger_o, 0);
        checkOutput("reset_busy", Busy_o, 0);
        checkOutput("reset_done", Done_o, 0);
        checkOutput("reset_timeout", Timeout_o, 0);
        checkOutput("reset_code", Error_code_o, 0);
        repeat (3) @(posedge Clk_i);
        #1;
        Reset_i = 1'b1;
        plan_idle(2);

        for (int i = 0; i < NVEC; i++) begin
            clear_meas();
            plan_shot(0, vecs[i].r_off, vecs[i].len, vecs[i].busy_off);
            plan_idle(2);
            run_until(plan_end);
            checkOutput($sformatf("v%0d_trig_rises", i), meas_rise_q.size(), 1);
            checkOutput($sformatf("v%0d_trig_start", i), nth(meas_rise_q, 0), last_s);
            checkOutput($sformatf("v%0d_trig_width", i), meas_trig_count, TRIG);
            checkOutput($sformatf("v%0d_event_off", i), nth(meas_event_q, 0) - (last_s + TRIG), vecs[i].exp_ev_off);
            checkOutput($sformatf("v%0d_event_kind", i), meas_event_kind, (vecs[i].exp_code == 0) ? 1 : 2);
            checkOutput($sformatf("v%0d_code", i), Error_code_o, vecs[i].exp_code);
            checkOutput($sformatf("v%0d_exit_off", i), nth(meas_exit_q, 0) - nth(meas_event_q, 0), vecs[i].exp_exit_off);
            checkOutput($sformatf("v%0d_pulses", i), meas_done_count + meas_to_count, 1);
        end

        clear_meas();
        plan_shot(1, 3, 10, 7);
        cont_s[0] = last_s;  cont_e[0] = last_e;
        plan_shot(1, 6, 20, 9);
        cont_s[1] = last_s;  cont_e[1] = last_e;
        plan_shot(2, 1, 5, 12);
        cont_s[2] = last_s;  cont_e[2] = last_e;
        plan_idle(60);
        run_until(plan_end);
        checkOutput("cont_triggers", meas_rise_q.size(), 3);
        checkOutput("cont_events", meas_done_count, 3);
        checkOutput("cont_gap1", nth(meas_rise_q, 1) - nth(meas_event_q, 0), cont_s[1] - cont_e[0]);
        checkOutput("cont_gap2", nth(meas_rise_q, 2) - nth(meas_event_q, 1), cont_s[2] - cont_e[1]);
        checkOutput("cont_rest_busy", Busy_o, 0);

        plan_shot(0, -1, 0, 0);
        plan_idle(1);
        run_until(plan_end);
        checkOutput("pre_trig_reset_code", Error_code_o, 1);
        plan_shot(0, 4, 6, 0);
        run_until(last_s + 3);
        reset_check("mid_trig");
        plan_idle(3);
        clear_meas();
        plan_shot(0, 4, 6, 0);
        plan_idle(2);
        run_until(plan_end);
        checkOutput("after_trig_reset_width", meas_trig_count, TRIG);
        checkOutput("after_trig_reset_start", nth(meas_rise_q, 0), last_s);

        plan_shot(0, 2, 95, 0);
        plan_idle(1);
        run_until(plan_end);
        checkOutput("pre_echo_reset_code", Error_code_o, 2);
        plan_shot(0, 2, 40, 0);
        run_until(last_s + TRIG + 15);
        reset_check("mid_echo");
        plan_idle(3);
        clear_meas();
        plan_shot(0, 5, 9, 0);
        plan_idle(2);
        run_until(plan_end);
        checkOutput("after_echo_reset_width", meas_trig_count, TRIG);
        checkOutput("after_echo_reset_done", meas_done_count, 1);

        for (int n = 0; n < 30; n++) begin
            r_off = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(0, RISE_TO + 4));
            len   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(MAXLEN - 3, MAXLEN + 40))
                                                : int'($urandom_range(1, MAXLEN));
            busy  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 100)) : 0;
            mode  = int'($urandom_range(0, 1));
            gap   = int'($urandom_range(0, 4));
            plan_shot(mode, r_off, len, busy);
            plan_idle(gap);
        end
        plan_idle(3);
        run_until(plan_end);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/ultrasonic_sensor_trigger.md
# ultrasonic_sensor_trigger

Initiator side of the HC-SR04 measurement protocol. It generates the trigger pulse and supervises the sensor's echo window with rise and length timeouts. It enforces the inter-measurement hold-off and reports each cycle's outcome as one-clock completion or timeout pulses. It sits beside the echo receiver, shares the raw echo pin, and runs the sensor in single-shot or continuous mode.

## Interface
- TRIG_CYCLES_P, 500, trigger pulse width in clocks (10 us at 50 MHz)
- ECHO_RISE_TIMEOUT_P, 50_000, max clocks from trigger fall to echo rise (1 ms)
- ECHO_MAX_CYCLES_P, 1_900_000, max echo high length in clocks (38 ms, sensor no-object)
- HOLDOFF_CYCLES_P, 3_000_000, minimum quiet time after a cycle ends (60 ms)
- COUNTER_WIDTH_P, 22, phase counter width; must hold the largest cycle parameter
- Clk_i  in  1  system clock
- Reset_i  in  1  reset, asynchronous, active-low
- Start_i  in  1  single-shot request, level, sampled only in IDLE
- Continuous_i  in  1  when high, a new cycle starts automatically from IDLE
- Echo_i  in  1  raw echo pin from the sensor, asynchronous
- Trigger_o  out  1  trigger pin to the sensor, registered
- Busy_o  out  1  high whenever state is not IDLE, registered
- Done_o  out  1  one-clock pulse on a valid echo fall
- Timeout_o  out  1  one-clock pulse on either timeout
- Error_code_o  out  2  result of the last cycle: 00 ok, 01 no echo rise, 10 echo too long; held until the next result

## Operation
- Echo_i passes through a 2-flop synchronizer. All decisions use the synchronized value echo_s.
- There is one phase counter. It clears on every state entry and increments each clock inside a state.
- IDLE: if Start_i or Continuous_i is high, go to TRIG. Otherwise stay.
- TRIG: Trigger_o is high. When the counter reaches TRIG_CYCLES_P-1, go to WAIT_RISE.
- WAIT_RISE:
  - If echo_s is 1, go to ECHO_HIGH.
  - Else, if the counter reaches ECHO_RISE_TIMEOUT_P-1, go to HOLDOFF, pulse Timeout_o and set Error_code_o=01.
- ECHO_HIGH:
  - If echo_s is 0, go to HOLDOFF, pulse Done_o and set Error_code_o=00.
  - Else, if the counter reaches ECHO_MAX_CYCLES_P-1, go to HOLDOFF, pulse Timeout_o and set Error_code_o=10.
- HOLDOFF: Echo edges are ignored. Leave for IDLE only when the counter has reached HOLDOFF_CYCLES_P-1 and echo_s is 0. If echo_s is still high, the counter saturates and the block waits.
- Simultaneous events:
  - Echo rise in the same cycle as the rise timeout: the echo wins, no timeout.
  - Echo fall in the same cycle as the max-length timeout: Done wins, Error_code_o=00.
- Start_i outside IDLE is ignored, not queued.
- Continuous_i dropping mid-cycle: the current cycle completes and the block then rests in IDLE.
- Reset mid-operation forces all outputs low immediately, with no partial trigger pulse afterwards.

## Timing
- Reset values: Trigger_o=0, Busy_o=0, Done_o=0, Timeout_o=0, Error_code_o=00, state IDLE, counter 0, synchronizer flops 0.
- Start_i high at edge N in IDLE: Trigger_o and Busy_o go high after edge N. Trigger_o stays high for exactly TRIG_CYCLES_P clocks.
- Echo pin latency: echo_s follows the pin by 2 clocks. Done_o asserts the clock after echo_s falls, so it comes 3 edges after the pin falls.
- Done_o and Timeout_o are never high together. Each is exactly one clock wide.
- Error_code_o updates on the same edge as the Done_o or Timeout_o pulse.
- Busy_o drops on the edge that enters IDLE.
- In continuous mode, the next Trigger_o rises 1 clock after entering IDLE. The gap is therefore at least HOLDOFF_CYCLES_P+1 clocks after the end of the echo phase.

## Test plan
Bench parameters: TRIG=5, RISE_TO=20, MAX=50, HOLDOFF=30.
- Single shot: Start_i pulse. Echo high 8 clocks after trigger fall, for 12 clocks. Expect Trigger_o high for 5 clocks, Done_o one pulse, Error_code_o=00, Busy_o low 30 clocks after Done_o.
- No echo: Start_i pulse, echo held low. Expect Timeout_o 20 clocks after trigger fall, Error_code_o=01, no Done_o.
- Long echo: echo held high 80 clocks. Expect Timeout_o at echo count 50, Error_code_o=10. HOLDOFF is extended until the echo falls, then IDLE.
- Tie cases: echo_s rises on the exact rise-timeout cycle, then echo_s falls on the exact max cycle. Expect no Timeout_o and one Done_o.
- Continuous mode: Continuous_i high for 3 cycles, then low. Expect exactly 3 trigger pulses spaced by at least 31 idle-inclusive clocks after each echo end. The block rests in IDLE. Start_i pulses while busy create no extra triggers.
- Reset mid-TRIG and mid-ECHO_HIGH: Reset_i low asynchronously. Expect Trigger_o, Busy_o, Done_o and Timeout_o low immediately and Error_code_o=00. After release, Start_i yields a full 5-clock trigger.
